// File: rtl/canny_div_pkg.sv
// ---------------------------------------------------------------------------
// canny_div_pkg
// Shared definitions for the sequential signed divider:
//   - sdiv_state_e : FSM state encoding (IDLE, CALC, FIXUP, DONE)
//   - SDIV_DIVIDEND_W / SDIV_DIVISOR_W : default operand widths
//   - SDIV_LAT : edges from the start-sampling edge until done is visible
//                (start edge + one edge per quotient bit + FIXUP edge)
// ---------------------------------------------------------------------------
package canny_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } sdiv_state_e;

  localparam int SDIV_DIVIDEND_W = 22;
  localparam int SDIV_DIVISOR_W  = 11;
  localparam int SDIV_LAT        = SDIV_DIVIDEND_W + 2;

endpackage

// File: rtl/canny_sdiv_step.sv
// ---------------------------------------------------------------------------
// canny_sdiv_step
// One unsigned restoring-division step (purely combinational).
//   prem_i : partial remainder, PW bits (PW = divisor width + 1)
//   bit_i  : next dividend bit, shifted in at the LSB
//   dsr_i  : divisor magnitude, PW bits
//   prem_o : partial remainder after the trial subtraction
//   qbit_o : quotient bit produced by this step
// ---------------------------------------------------------------------------
module canny_sdiv_step #(
  parameter int PW = 12
) (
  input  logic [PW-1:0] prem_i,
  input  logic          bit_i,
  input  logic [PW-1:0] dsr_i,
  output logic [PW-1:0] prem_o,
  output logic          qbit_o
);

  logic [PW-1:0] shifted;
  logic [PW:0]   trial;
  logic          unused_prem_msb;

  // The partial remainder is always below the divisor magnitude
  // (at most 2^(PW-2)), so its top bit is zero and can be dropped
  // by the shift without loss.
  assign unused_prem_msb = prem_i[PW-1];
  assign shifted         = {prem_i[PW-2:0], bit_i};
  assign trial           = {1'b0, shifted} - {1'b0, dsr_i};

  // No borrow out of the trial subtraction means the divisor fits.
  assign qbit_o = ~trial[PW];
  assign prem_o = qbit_o ? trial[PW-1:0] : shifted;

endmodule

// File: rtl/canny_sdiv_22s_11s_seq.sv
// ---------------------------------------------------------------------------
// canny_sdiv_22s_11s_seq
// Sequential signed divider, one restoring step per cycle, truncating toward
// zero (remainder carries the sign of the dividend).
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset, clears all state
//   ce       : clock enable, freezes all state when low
//   start    : begin a division (sampled only in IDLE with ce=1)
//   din0     : signed dividend (DIVIDEND_W)
//   din1     : signed divisor  (DIVISOR_W)
//   ready    : high only in IDLE
//   done     : high while in DONE (one ce-qualified cycle)
//   quot     : signed quotient, held from DONE until the next FIXUP
//   rem      : signed remainder, held likewise
//   div_zero : divide-by-zero flag, valid with done
//
// Build option: define CANNY_SDIV_DIVZERO_EN to enable the zero-divisor
// fast path (IDLE -> FIXUP, saturated quotient, div_zero=1). Without it,
// div_zero is tied low and zero divisors run the normal CALC path.
// ---------------------------------------------------------------------------
module canny_sdiv_22s_11s_seq
  import canny_div_pkg::*;
#(
  parameter int DIVIDEND_W = SDIV_DIVIDEND_W,
  parameter int DIVISOR_W  = SDIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  ready,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  div_zero
);

  localparam int PW    = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  sdiv_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Holds |dividend| at start; quotient bits shift in from the LSB as
  // dividend bits leave from the MSB, so it ends up holding |quotient|.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [PW-1:0]         dsr_q, dsr_d;
  logic [PW-1:0]         prem_q, prem_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
`ifdef CANNY_SDIV_DIVZERO_EN
  logic                  dz_q, dz_d;
  logic                  divz_q, divz_d;
`endif

  logic [PW-1:0] step_prem;
  logic          step_qbit;
  logic [PW-1:0] din1_ext;

  // Sign-extend before taking the magnitude so that |-2^(DIVISOR_W-1)| fits.
  assign din1_ext = {din1[DIVISOR_W-1], din1};

  canny_sdiv_step #(
    .PW (PW)
  ) u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[DIVIDEND_W-1]),
    .dsr_i  (dsr_q),
    .prem_o (step_prem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef CANNY_SDIV_DIVZERO_EN
    dz_d    = dz_q;
    divz_d  = divz_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          dvd_d   = din0[DIVIDEND_W-1] ? -din0 : din0;
          dsr_d   = din1[DIVISOR_W-1] ? -din1_ext : din1_ext;
          prem_d  = '0;
          qneg_d  = din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
          rneg_d  = din0[DIVIDEND_W-1];
`ifdef CANNY_SDIV_DIVZERO_EN
          dz_d    = (din1 == '0);
          if (din1 == '0) state_d = S_FIXUP;
`endif
        end
      end
      S_CALC: begin
        prem_d = step_prem;
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], step_qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        // Two's-complement negation wraps -2^(W-1)/-1 back onto itself.
        quot_d  = qneg_q ? -dvd_q : dvd_q;
        rem_d   = rneg_q ? -prem_q[DIVISOR_W-1:0] : prem_q[DIVISOR_W-1:0];
`ifdef CANNY_SDIV_DIVZERO_EN
        divz_d  = dz_q;
        if (dz_q) begin
          quot_d = rneg_q ? {1'b1, {(DIVIDEND_W-1){1'b0}}}
                          : {1'b0, {(DIVIDEND_W-1){1'b1}}};
          rem_d  = '0;
        end
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef CANNY_SDIV_DIVZERO_EN
      dz_q    <= 1'b0;
      divz_q  <= 1'b0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef CANNY_SDIV_DIVZERO_EN
      dz_q    <= dz_d;
      divz_q  <= divz_d;
`endif
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign quot  = quot_q;
  assign rem   = rem_q;
`ifdef CANNY_SDIV_DIVZERO_EN
  assign div_zero = divz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_canny_sdiv_22s_11s_seq.sv
// ---------------------------------------------------------------------------
// tb_canny_sdiv_22s_11s_seq
// Self-checking bench: a driver issues directed and random divisions, a
// reference model built on integer division predicts each result, and a
// monitor compares every done pulse against the model and checks that the
// outputs hold steady at all other times.
// ---------------------------------------------------------------------------
module tb_canny_sdiv_22s_11s_seq;

  localparam int DW  = 22;
  localparam int VW  = 11;
  localparam int LAT = DW + 2;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] din0 = '0;
  logic [VW-1:0] din1 = '0;
  logic          ready, done, div_zero;
  logic [DW-1:0] quot;
  logic [VW-1:0] rem;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  exp_t held = '{q: '0, r: '0, dz: 1'b0};
  logic prev_done = 1'b0;
  int   done_cnt  = 0;

  logic signed [DW-1:0] last_q;
  logic signed [VW-1:0] last_r;
  logic                 last_dz;

  canny_sdiv_22s_11s_seq #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (VW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .ready    (ready),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: C-style truncating division on wide integers, truncated to
  // the output widths (this also yields the wrap for -2^(DW-1) / -1).
  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint t;
    longint m;
    if (b == 0) begin
      e.dz = 1'b1;
      e.r  = '0;
      e.q  = (a < 0) ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      t    = a / b;
      m    = a % b;
      e.q  = t[DW-1:0];
      e.r  = m[VW-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: first negedge of each done episode is compared to the model;
  // every other sampled cycle must show the previously delivered result.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_quot", quot, e.q);
          chk("mon_rem", rem, e.r);
          chk("mon_dz", div_zero, e.dz);
          held    = e;
          last_q  = quot;
          last_r  = rem;
          last_dz = div_zero;
        end
      end else begin
        chk("hold_outputs", {quot, rem, div_zero}, {held.q, held.r, held.dz});
      end
      prev_done = done;
    end
  end

  // cemode: 0 = ce high, 1 = ce alternates, 2 = ce random (75% high).
  // spam: keep start high with junk operands while busy.
  task automatic do_op(input longint a, input longint b, input int cemode, input bit spam);
    int   n_hi;
    int   guard;
    bit   seen;
    int   exp_lat;
    logic [DW-1:0] a_v;
    logic [VW-1:0] b_v;
    a_v = a[DW-1:0];
    b_v = b[VW-1:0];
    exp_lat = LAT;
`ifdef CANNY_SDIV_DIVZERO_EN
    if (b == 0) exp_lat = 2;
`endif
    @(negedge clk);
    ce = 1'b1;
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_start", ready, 1);
    din0  = a_v;
    din1  = b_v;
    start = 1'b1;
    ce    = 1'b1;
    exp_q.push_back(model(a, b));
    n_hi = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      if (ce) n_hi++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else chk("ready_low_busy", ready, 0);
      start = spam;
      din0  = DW'($urandom);
      din1  = VW'($urandom);
      case (cemode)
        1:       ce = ~ce;
        2:       ce = ($urandom_range(0, 3) != 0);
        default: ce = 1'b1;
      endcase
    end
    start = 1'b0;
    ce    = 1'b1;
    chk("done_seen", seen, 1);
    chk("latency_ce_edges", n_hi, exp_lat);
    #1;
  endtask

  initial begin
    longint a, b;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    int dc;

    // Reset state
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Directed cases with hand-computed results
    do_op(100, 7, 0, 0);
    chk("q_100_7", last_q, 14);
    chk("r_100_7", last_r, 2);
    do_op(-100, 7, 0, 0);
    chk("q_m100_7", last_q, -14);
    chk("r_m100_7", last_r, -2);
    do_op(100, -7, 0, 0);
    chk("q_100_m7", last_q, -14);
    chk("r_100_m7", last_r, 2);
    do_op(-2097152, -1, 0, 0);
    chk("q_ovf", last_q, -2097152);
    chk("r_ovf", last_r, 0);
    chk("dz_ovf", last_dz, 0);
    do_op(2097151, -1024, 0, 0);
    chk("q_max_minv", last_q, -2047);
    chk("r_max_minv", last_r, 1023);

    // Stalls: ce alternates during the operation
    do_op(1000, 3, 1, 0);
    chk("q_1000_3", last_q, 333);
    chk("r_1000_3", last_r, 1);

    // start held high while busy: only one result per accepted start
    dc = done_cnt;
    do_op(12345, -77, 0, 1);
    repeat (30) @(negedge clk);
    chk("one_done_per_start", done_cnt - dc, 1);
    chk("q_12345_m77", last_q, -160);
    chk("r_12345_m77", last_r, 25);

    // Reset in the middle of CALC
    @(negedge clk);
    din0 = DW'(1000);
    din1 = VW'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quot, 0);
    chk("midrst_rem", rem, 0);
    held = '{q: '0, r: '0, dz: 1'b0};
    exp_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    do_op(50, 5, 0, 0);
    chk("q_50_5", last_q, 10);
    chk("r_50_5", last_r, 0);

`ifdef CANNY_SDIV_DIVZERO_EN
    do_op(-5, 0, 0, 0);
    chk("q_m5_0", last_q, -2097152);
    chk("r_m5_0", last_r, 0);
    chk("dz_m5_0", last_dz, 1);
`endif

    // Random operands with random ce
    for (int k = 0; k < 40; k++) begin
      ra = DW'($urandom);
      rb = VW'($urandom);
      if (k % 8 == 0) ra = {1'b1, {(DW-1){1'b0}}};
      if (k % 8 == 1) rb = {1'b1, {(VW-1){1'b0}}};
`ifndef CANNY_SDIV_DIVZERO_EN
      if (rb == '0) rb = VW'(1);
`endif
      a = longint'($signed(ra));
      b = longint'($signed(rb));
      do_op(a, b, (k % 2 == 0) ? 2 : 0, (k % 5 == 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canny_sdiv_22s_11s_seq.md
CANNY_SDIV_22S_11S_SEQ -- requirements
Module: canny_sdiv_22s_11s_seq

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 22, the signed dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 11, the signed divisor and remainder width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ce, input, 1, clock enable; when low, all state is frozen.
REQ-006 SHALL have port start, input, 1, the request to begin a division; sampled only in IDLE with ce=1.
REQ-007 SHALL have port din0, input, DIVIDEND_W, the signed dividend, captured on start.
REQ-008 SHALL have port din1, input, DIVISOR_W, the signed divisor, captured on start.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-011 SHALL have port quot, output, DIVIDEND_W, the signed quotient.
REQ-012 SHALL have port rem, output, DIVISOR_W, the signed remainder.
REQ-013 SHALL have port div_zero, output, 1, the divide-by-zero flag, valid with done.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC, FIXUP and DONE; all transitions are qualified by ce=1.
REQ-015 IDLE SHALL go to CALC when start=1; on that edge it latches |din0|, |din1|, sign(din0) and sign(din0) xor sign(din1).
REQ-016 CALC SHALL perform one unsigned restoring step per cycle for exactly DIVIDEND_W cycles.
- Partial remainder is DIVISOR_W+1 bits wide, so |−2^(DIVISOR_W−1)| is representable.
REQ-017 FIXUP SHALL apply the signs, then go to DONE.
- Quotient is negated if the signs differ.
- Remainder takes the sign of the dividend (truncation toward zero, C semantics).
REQ-018 DONE SHALL assert done=1 for exactly one ce-qualified cycle, then return to IDLE.
REQ-019 Latency SHALL be fixed: with ce held high, start sampled at edge 0 gives done=1 in the cycle after edge DIVIDEND_W+2 (24 by default).
REQ-020 quot and rem SHALL hold their value from DONE until the next FIXUP; they never change in IDLE or CALC.
REQ-021 start SHALL be ignored while ready=0; no queuing, no error.
REQ-022 ce low mid-operation SHALL stretch latency cycle-for-cycle; done stays high until a ce-high edge consumes it.
REQ-023 Overflow case −2^(DIVIDEND_W−1) / −1 SHALL wrap two's-complement: quot=−2^(DIVIDEND_W−1), rem=0, no flag.

Reset
REQ-024 Asserting reset at any time, including mid-CALC, SHALL immediately force IDLE, ready=1, done=0, quot=0, rem=0, div_zero=0, and clear all internal registers.
REQ-025 After reset deasserts, the first ce-qualified start SHALL be accepted normally.

Configuration
REQ-026 Macro CANNY_SDIV_DIVZERO_EN SHALL enable the zero-divisor fast path.
- Defined: din1=0 at start goes IDLE→FIXUP directly, so done appears 2 cycles after start.
- Defined results: div_zero=1, rem=0, quot=+2^(DIVIDEND_W−1)−1 for dividend ≥0, else −2^(DIVIDEND_W−1).
- Undefined: div_zero is tied 0, zero divisors run the normal CALC path, and quot/rem for them are unspecified.

Structure
REQ-027 Package canny_div_pkg SHALL hold:
- the state enum type;
- default width constants;
- the latency constant SDIV_LAT = DIVIDEND_W+2.
REQ-028 One combinational sub-module canny_sdiv_step SHALL compute a single restoring step (shift, trial subtract, quotient bit); it is instantiated once and reused every CALC cycle.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- 100/7 → quot=14, rem=2, done exactly 24 cycles after start; −100/7 → −14, −2; 100/−7 → −14, 2.
- −2097152/−1 → quot=−2097152, rem=0, div_zero=0; 2097151/−1024 → quot=−2047, rem=1023.
- ce toggled 50% during CALC on 1000/3 → quot=333, rem=1; done latency equals 24 plus the count of ce-low cycles; outputs unchanged during stalls.
- start pulsed every cycle while busy → exactly one done per accepted start; ready low throughout CALC/FIXUP/DONE.
- reset asserted at CALC cycle 10 → next cycle ready=1, done=0, quot=0; a following 50/5 → quot=10, rem=0.
- With CANNY_SDIV_DIVZERO_EN: −5/0 → done 2 cycles after start, div_zero=1, quot=−2097152, rem=0.
